// File: rtl/fir_seq_ctrl.sv
// Band FIR sequencer: steps the coefficient ROM in lock-step with the band
// queue burst and MACs left/right samples into one saturated Q1.15 pair.
module fir_seq_ctrl #(
  parameter int NUM_TAPS = 1021,
  parameter int ADDR_W   = 10,
  parameter int ACC_W    = 42
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sequencing,
  input  logic [15:0]       lft_smpl,
  input  logic [15:0]       rght_smpl,
  input  logic [15:0]       coeff,
  output logic [ADDR_W-1:0] coeff_addr,
  output logic [15:0]       lft_out,
  output logic [15:0]       rght_out,
  output logic              vld,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_TAPS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] tap;
  logic [ACC_W-1:0]  acc_l;
  logic [ACC_W-1:0]  acc_r;
  logic signed [31:0] prod_l;
  logic signed [31:0] prod_r;
  logic              last_tap;
  logic              abort;

  assign prod_l   = $signed(lft_smpl) * $signed(coeff);
  assign prod_r   = $signed(rght_smpl) * $signed(coeff);
  assign last_tap = (tap == LAST);
  assign abort    = (state == ACCUM) && !sequencing && !last_tap;

  // Takes acc[ACC_W-1:15]; result is acc[30:15] unless the guard bits overflow
  function automatic logic [15:0] sat16(
    input logic [ACC_W-16:0] a
  );
    logic [ACC_W-31:0] hi;
    hi = a[ACC_W-16:15];
    if (&hi || ~|hi)
      sat16 = a[15:0];
    else if (a[ACC_W-16])
      sat16 = 16'h8000;
    else
      sat16 = 16'h7fff;
  endfunction

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (sequencing) state_nxt = ACCUM;
      ACCUM: begin
        if (abort)
          state_nxt = IDLE;
        else if (last_tap)
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ACCUM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tap        <= '0;
      coeff_addr <= '0;
      acc_l      <= '0;
      acc_r      <= '0;
      lft_out    <= '0;
      rght_out   <= '0;
      vld        <= 1'b0;
      err        <= 1'b0;
    end else begin
      vld <= 1'b0;
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          tap <= '0;
          if (sequencing) begin
            coeff_addr <= ADDR_W'(1);
            acc_l      <= '0;
            acc_r      <= '0;
          end else begin
            coeff_addr <= '0;
          end
        end
        ACCUM: begin
          if (abort) begin
            err        <= 1'b1;
            tap        <= '0;
            coeff_addr <= '0;
            acc_l      <= '0;
            acc_r      <= '0;
          end else begin
            tap   <= tap + 1'b1;
            acc_l <= acc_l + {{(ACC_W-32){prod_l[31]}}, prod_l};
            acc_r <= acc_r + {{(ACC_W-32){prod_r[31]}}, prod_r};
            if (coeff_addr < LAST)
              coeff_addr <= coeff_addr + 1'b1;
          end
        end
        DONE: begin
          lft_out    <= sat16(acc_l[ACC_W-1:15]);
          rght_out   <= sat16(acc_r[ACC_W-1:15]);
          vld        <= 1'b1;
          tap        <= '0;
          coeff_addr <= '0;
        end
        default: begin
          tap        <= '0;
          coeff_addr <= '0;
        end
      endcase
    end
  end

endmodule
